// File: rtl/ss_sng_lfsr.sv
// Stochastic number generator: converts an N-bit unsigned value into a
// stream of L bits whose density of ones approximates VAL/2^N. Each stream
// bit compares a free-running Galois LFSR against the latched value.
module ss_sng_lfsr #(
  parameter int unsigned  N    = 16,
  parameter int unsigned  L    = 1024,
  parameter logic [N-1:0] TAPS = 16'hB400,
  parameter logic [N-1:0] SEED = 16'hACE1
) (
  input  logic         CLK,
  input  logic         INIT,
  input  logic [N-1:0] VAL,
  input  logic         LOAD,
  output logic         BUSY,
  output logic         OUT,
  output logic         OUT_VALID,
  output logic         DONE,
  output logic [15:0]  COUNT
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [N-1:0] SEED_EFF = (SEED == '0) ? {{(N-1){1'b0}}, 1'b1} : SEED;
  localparam logic [15:0]  LAST     = 16'(L - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] lfsr_q;
  logic [N-1:0] lfsr_next;
  logic [N-1:0] vreg_q;
  logic [15:0]  count_q;
  logic [15:0]  run_cnt_q;
  logic         accept;
  logic         in_run;

  // State register.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; FIN accepts LOAD exactly like IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (LOAD) state_d = StRun;
      StRun:   if (run_cnt_q == LAST) state_d = StFin;
      StFin:   state_d = LOAD ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    in_run    = (state_q == StRun);
    OUT_VALID = in_run;
    BUSY      = in_run;
    DONE      = (state_q == StFin);
    OUT       = in_run && (lfsr_q < vreg_q);
    COUNT     = count_q;
    accept    = LOAD && (state_q != StRun);
    lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  end

  // Datapath: value latch, ones counter, run length counter and LFSR.
  // The LFSR is never reseeded between runs, only by INIT.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      lfsr_q    <= SEED_EFF;
      vreg_q    <= '0;
      count_q   <= '0;
      run_cnt_q <= '0;
    end else if (accept) begin
      vreg_q    <= VAL;
      count_q   <= '0;
      run_cnt_q <= '0;
    end else if (in_run) begin
      lfsr_q    <= lfsr_next;
      run_cnt_q <= run_cnt_q + 16'd1;
      if (OUT) count_q <= count_q + 16'd1;
    end
  end

endmodule
